dest_addr_collect: RTL
======================

Name: dest_addr_collect

Overview:
- Downstream consumer of the rotating one-hot destination selector (S0/S1/S2).
- Captures three successive data nibbles strobed by LDD into a working register, one nibble per selector position.
- On the third nibble, publishes the assembled 3-nibble destination word with a VALID/TAKE handshake to the program-counter/jump-target load logic.
- Flags selector-sequence errors and overruns as sticky status bits.

Parameters:
- NIB_W, 4, width of one data nibble; output word is 3*NIB_W bits.

Ports:
- CLK  in  1  system clock, rising-edge.
- RST  in  1  reset, asynchronous, active-high.
- LDD  in  1  load-destination strobe, sampled on CLK rising edge.
- S0  in  1  selector one-hot bit, middle nibble.
- S1  in  1  selector one-hot bit, high nibble.
- S2  in  1  selector one-hot bit, low nibble (the selector's reset state).
- DIN  in  NIB_W  data nibble to capture.
- TAKE  in  1  consumer accepts ADDR this cycle.
- ADDR  out  3*NIB_W  published destination word.
- VALID  out  1  ADDR holds an unconsumed word.
- BUSY  out  1  collection in progress (1 or 2 nibbles held).
- SEQERR  out  1  sticky: LDD seen with a bad or out-of-order select.
- OVR  out  1  sticky: completing nibble arrived while VALID and no TAKE.

Behaviour:
- Reset (async, RST=1): working register=0, ADDR=0, VALID=0, BUSY=0, SEQERR=0, OVR=0, count=0. Takes effect immediately and mid-collection; any partial word is discarded.
- Nibble mapping:
  - S2 → ADDR[NIB_W-1:0].
  - S0 → ADDR[2*NIB_W-1:NIB_W].
  - S1 → ADDR[3*NIB_W-1:2*NIB_W].
- Expected order is S2, S0, S1, matching the selector rotation from reset.
- Nibble count state (2 bits) is the state machine: C0 (empty) → C1 → C2 → C0 (publish).
- An LDD write is accepted when the select is exactly one-hot and matches the count: C0 needs S2, C1 needs S0, C2 needs S1.
- Accepted write in C0 or C1: store DIN into the working nibble, advance the count. BUSY=1 in C1/C2.
- Accepted write in C2:
  - If VALID=0 or TAKE=1 that cycle: ADDR <= {DIN, work_mid, work_low}, VALID=1 the next cycle (latency 1 clock from the strobe edge), count→C0.
  - If VALID=1 and TAKE=0: write dropped, OVR set, count stays C2 so a retry of the S1 nibble is possible.
- Rejected write (not one-hot or wrong position): no data change, count unchanged, SEQERR set.
- LDD=0: no state change except the handshake.
- Handshake:
  - TAKE with VALID=1 clears VALID next cycle.
  - TAKE with VALID=0 is ignored.
  - TAKE and a completing write in the same cycle: ADDR takes the new word and VALID stays 1.
- ADDR is stable while VALID=1 and no TAKE occurs.
- Writes in C0/C1 are accepted regardless of VALID, so collection of the next word overlaps the pending one.
- SEQERR and OVR clear only on RST.
- All outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Shared package holds:
  - NIB_W default.
  - Count encodings C0=2'd0, C1=2'd1, C2=2'd2.
  - Expected-select constants 3'b100 (S2), 3'b001 (S0), 3'b010 (S1), packed as {S2,S1,S0}.
- One natural sub-module: sel_check, a combinational one-hot and position-match checker producing accept/seqerr.
- The registers stay in the top block.

Test Plan:
- Reset, then LDD with S2/DIN=4'hA, S0/4'h5, S1/4'h3 on consecutive cycles → after the third edge ADDR=12'h35A, VALID=1, BUSY=0, SEQERR=0.
- Hold VALID, send S2/4'h1, S0/4'h2, then S1/4'h7 with TAKE=0 → ADDR stays 12'h35A, OVR=1, count remains C2; retry S1/4'h7 with TAKE=1 → ADDR=12'h721, VALID=1.
- LDD with S0 in C0 → SEQERR=1, count=C0, ADDR unchanged; LDD with select 3'b110 → no write, SEQERR stays 1.
- Load S2/4'hF and S0/4'hE, assert RST mid-cycle (asynchronously) → all outputs 0 immediately; next full sequence 4'h1, 4'h2, 4'h3 → ADDR=12'h321.
- VALID=1, TAKE=1 with LDD=0 → VALID=0 next cycle, ADDR held; TAKE with VALID=0 → no change.
- NIB_W=8: sequence 8'h11, 8'h22, 8'h33 → ADDR=24'h332211.

Source files
------------

// File: rtl/dest_addr_collect_pkg.sv
// Shared definitions for the destination-address collector: nibble count
// encodings and the selector pattern each count position expects.
package dest_addr_collect_pkg;

  localparam int NIB_W_DEF = 4;

  typedef enum logic [1:0] {
    C0 = 2'd0,
    C1 = 2'd1,
    C2 = 2'd2
  } cntState_t;

  // Selector patterns packed as {S2,S1,S0}
  localparam logic [2:0] SEL_S2 = 3'b100;
  localparam logic [2:0] SEL_S0 = 3'b001;
  localparam logic [2:0] SEL_S1 = 3'b010;

  function automatic logic [2:0] expectedSel(input cntState_t count);
    case (count)
      C0:      expectedSel = SEL_S2;
      C1:      expectedSel = SEL_S0;
      C2:      expectedSel = SEL_S1;
      default: expectedSel = 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/dest_addr_collect_sel_check.sv
// Combinational selector checker: a strobe is accepted only when the select
// is one-hot and matches the position the nibble count is waiting for.
module dest_addr_collect_sel_check
  import dest_addr_collect_pkg::*;
(
  input  logic      ldd,
  input  logic [2:0] sel,
  input  cntState_t count,
  output logic      accept,
  output logic      seqErr
);

  logic [2:0] wantSel;
  logic       oneHot;

  always_comb begin
    wantSel = expectedSel(count);
    oneHot  = $onehot(sel);
    accept  = ldd && oneHot && (sel == wantSel);
    seqErr  = ldd && !accept;
  end

endmodule

// File: rtl/dest_addr_collect.sv
// Collects three selector-strobed nibbles into a destination word and
// publishes it with a VALID/TAKE handshake; sticky sequence/overrun flags.
module dest_addr_collect
  import dest_addr_collect_pkg::*;
#(
  parameter int NIB_W = NIB_W_DEF
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               LDD,
  input  logic               S0,
  input  logic               S1,
  input  logic               S2,
  input  logic [NIB_W-1:0]   DIN,
  input  logic               TAKE,
  output logic [3*NIB_W-1:0] ADDR,
  output logic               VALID,
  output logic               BUSY,
  output logic               SEQERR,
  output logic               OVR
);

  cntState_t          count, countNext;
  logic [NIB_W-1:0]   workLow, workLowNext;
  logic [NIB_W-1:0]   workMid, workMidNext;
  logic [3*NIB_W-1:0] addrReg, addrNext;
  logic               validReg, validNext;
  logic               busyReg;
  logic               seqErrReg, seqErrNext;
  logic               ovrReg, ovrNext;
  logic               accept, badSel;

  dest_addr_collect_sel_check selCheck (
    .ldd    (LDD),
    .sel    ({S2, S1, S0}),
    .count  (count),
    .accept (accept),
    .seqErr (badSel)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      count     <= C0;
      workLow   <= '0;
      workMid   <= '0;
      addrReg   <= '0;
      validReg  <= 1'b0;
      busyReg   <= 1'b0;
      seqErrReg <= 1'b0;
      ovrReg    <= 1'b0;
    end else begin
      count     <= countNext;
      workLow   <= workLowNext;
      workMid   <= workMidNext;
      addrReg   <= addrNext;
      validReg  <= validNext;
      busyReg   <= (countNext != C0);
      seqErrReg <= seqErrNext;
      ovrReg    <= ovrNext;
    end
  end

  // The final nibble publishes only if the previous word is gone or leaving
  // this cycle; otherwise it is dropped and the count parks in C2 for a retry.
  always_comb begin
    countNext   = count;
    workLowNext = workLow;
    workMidNext = workMid;
    addrNext    = addrReg;
    validNext   = validReg;
    seqErrNext  = seqErrReg || badSel;
    ovrNext     = ovrReg;

    if (TAKE && validReg) validNext = 1'b0;

    if (accept) begin
      case (count)
        C0: begin
          workLowNext = DIN;
          countNext   = C1;
        end
        C1: begin
          workMidNext = DIN;
          countNext   = C2;
        end
        C2: begin
          if (!validReg || TAKE) begin
            addrNext  = {DIN, workMid, workLow};
            validNext = 1'b1;
            countNext = C0;
          end else begin
            ovrNext = 1'b1;
          end
        end
        default: countNext = C0;
      endcase
    end
  end

  assign ADDR   = addrReg;
  assign VALID  = validReg;
  assign BUSY   = busyReg;
  assign SEQERR = seqErrReg;
  assign OVR    = ovrReg;

endmodule
